// File: rtl/piggy_pkg.sv
// Shared types and constants for the coin-total report scheduler.
package piggy_pkg;

  localparam int unsigned FRAME_LEN = 18;
  localparam int unsigned IDX_W     = 5;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned DIGITS_W  = 24;

  localparam logic [BYTE_W-1:0] CR = 8'h0D;
  localparam logic [BYTE_W-1:0] LF = 8'h0A;

  localparam logic [BYTE_W-1:0] DEF_TAG0 = 8'h54;  // 'T' 10 baht
  localparam logic [BYTE_W-1:0] DEF_TAG1 = 8'h46;  // 'F' 5 baht
  localparam logic [BYTE_W-1:0] DEF_TAG2 = 8'h57;  // 'W' 2 baht
  localparam logic [BYTE_W-1:0] DEF_TAG3 = 8'h4F;  // 'O' 1 baht

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SNAP = 2'd1,
    SEND = 2'd2,
    GAP  = 2'd3
  } state_t;

  // Coherent copy of the four 3-digit ASCII totals taken at SNAP.
  typedef struct packed {
    logic [DIGITS_W-1:0] a3;
    logic [DIGITS_W-1:0] a2;
    logic [DIGITS_W-1:0] a1;
    logic [DIGITS_W-1:0] a0;
  } snap_t;

endpackage

// File: rtl/frame_byte_mux.sv
// Selects the frame byte for a given index from the snapshot and tags.
module frame_byte_mux
  import piggy_pkg::*;
#(
  parameter logic [BYTE_W-1:0] TAG0 = DEF_TAG0,
  parameter logic [BYTE_W-1:0] TAG1 = DEF_TAG1,
  parameter logic [BYTE_W-1:0] TAG2 = DEF_TAG2,
  parameter logic [BYTE_W-1:0] TAG3 = DEF_TAG3
) (
  input  logic [IDX_W-1:0]  idx,
  input  snap_t             snap,
  output logic [BYTE_W-1:0] byte_c
);

  logic [BYTE_W-1:0]   rec_tag;
  logic [DIGITS_W-1:0] rec_digits;

  // Pick the record (tag + digits) addressed by the upper index bits.
  always_comb begin
    rec_tag    = TAG0;
    rec_digits = snap.a0;
    unique case (idx[3:2])
      2'd0: begin rec_tag = TAG0; rec_digits = snap.a0; end
      2'd1: begin rec_tag = TAG1; rec_digits = snap.a1; end
      2'd2: begin rec_tag = TAG2; rec_digits = snap.a2; end
      2'd3: begin rec_tag = TAG3; rec_digits = snap.a3; end
    endcase
  end

  // Records occupy indices 0..15 (tag then MSD..LSD); CR/LF close the frame.
  always_comb begin
    byte_c = 8'h00;
    if (idx < IDX_W'(16)) begin
      unique case (idx[1:0])
        2'd0: byte_c = rec_tag;
        2'd1: byte_c = rec_digits[23:16];
        2'd2: byte_c = rec_digits[15:8];
        2'd3: byte_c = rec_digits[7:0];
      endcase
    end else if (idx == IDX_W'(16)) begin
      byte_c = CR;
    end else if (idx == IDX_W'(17)) begin
      byte_c = LF;
    end
  end

endmodule

// File: rtl/coin_report_scheduler.sv
// Coalesces coin-total change events and emits one 18-byte report frame
// over a valid/ready byte link, with an enforced idle gap between frames.
module coin_report_scheduler
  import piggy_pkg::*;
#(
  parameter int unsigned       GAP_CYCLES = 16,
  parameter logic [BYTE_W-1:0] TAG0       = DEF_TAG0,
  parameter logic [BYTE_W-1:0] TAG1       = DEF_TAG1,
  parameter logic [BYTE_W-1:0] TAG2       = DEF_TAG2,
  parameter logic [BYTE_W-1:0] TAG3       = DEF_TAG3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          change,
  input  logic                force_req,
  input  logic [DIGITS_W-1:0] ascii0,
  input  logic [DIGITS_W-1:0] ascii1,
  input  logic [DIGITS_W-1:0] ascii2,
  input  logic [DIGITS_W-1:0] ascii3,
  output logic [BYTE_W-1:0]   tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                busy,
  output logic                frame_done,
  output logic [3:0]          pending
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  state_t             state, state_next;
  logic [IDX_W-1:0]   idx, idx_next;
  logic [GAP_W-1:0]   gap_cnt, gap_next;
  snap_t              snap, snap_next;
  logic               force_flag, force_next;
  logic [3:0]         pending_next;
  logic [BYTE_W-1:0]  byte_c, tx_data_next;
  logic               tx_valid_next, busy_next, frame_done_next;

  // Byte for the next presented index, computed from the next snapshot so
  // tx_data is already correct on the first SEND cycle.
  frame_byte_mux #(
    .TAG0(TAG0),
    .TAG1(TAG1),
    .TAG2(TAG2),
    .TAG3(TAG3)
  ) u_mux (
    .idx   (idx_next),
    .snap  (snap_next),
    .byte_c(byte_c)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      gap_cnt    <= '0;
      snap       <= '0;
      force_flag <= 1'b0;
      pending    <= 4'b0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      idx        <= idx_next;
      gap_cnt    <= gap_next;
      snap       <= snap_next;
      force_flag <= force_next;
      pending    <= pending_next;
      tx_data    <= tx_data_next;
      tx_valid   <= tx_valid_next;
      busy       <= busy_next;
      frame_done <= frame_done_next;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_next      = state;
    idx_next        = idx;
    gap_next        = gap_cnt;
    snap_next       = snap;
    pending_next    = pending | change;
    force_next      = force_flag | force_req;
    tx_valid_next   = 1'b0;
    frame_done_next = 1'b0;

    unique case (state)
      IDLE: begin
        if (((pending | change) != 4'b0) || force_flag || force_req) begin
          state_next = SNAP;
        end
      end
      SNAP: begin
        snap_next.a0  = ascii0;
        snap_next.a1  = ascii1;
        snap_next.a2  = ascii2;
        snap_next.a3  = ascii3;
        // Events seen in this cycle survive for the following frame.
        pending_next  = change;
        force_next    = force_req;
        idx_next      = '0;
        tx_valid_next = 1'b1;
        state_next    = SEND;
      end
      SEND: begin
        tx_valid_next = 1'b1;
        if (tx_ready) begin
          if (idx == IDX_W'(FRAME_LEN - 1)) begin
            tx_valid_next   = 1'b0;
            frame_done_next = 1'b1;
            idx_next        = '0;
            gap_next        = '0;
            if (GAP_CYCLES == 0) begin
              state_next = IDLE;
            end else begin
              state_next = GAP;
            end
          end else begin
            idx_next = idx + IDX_W'(1);
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
          gap_next   = '0;
          state_next = IDLE;
        end else begin
          gap_next = gap_cnt + GAP_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    busy_next    = (state_next != IDLE);
    tx_data_next = tx_valid_next ? byte_c : 8'h00;
  end

endmodule

// File: doc/coin_report_scheduler.md
Name: coin_report_scheduler

Overview:
- Sequences reporting of the four coin-denomination totals over the shared byte-level UART transmitter.
- Collects per-denomination change pulses and coalesces them into pending flags.
- When the link is free, snapshots all four 3-digit ASCII totals coherently and emits one fixed 18-byte frame through a valid/ready byte interface.
- Sits between the counter/num-to-ascii stage and the byte UART TX; replaces the OR-of-change start trigger.

Parameters:
- GAP_CYCLES, 16, idle clocks enforced between the end of one frame and the start of the next (0 = back-to-back allowed).
- TAG0, 8'h54 ('T'), tag byte for the 10-baht record.
- TAG1, 8'h46 ('F'), tag byte for the 5-baht record.
- TAG2, 8'h57 ('W'), tag byte for the 2-baht record.
- TAG3, 8'h4F ('O'), tag byte for the 1-baht record.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- change  input  4  one-cycle change pulses; bit0 = 10 baht ... bit3 = 1 baht
- force_req  input  1  one-cycle request to send a frame even if nothing changed
- ascii0  input  24  10-baht total, 3 ASCII digits, [23:16] = most-significant digit
- ascii1  input  24  5-baht total
- ascii2  input  24  2-baht total
- ascii3  input  24  1-baht total
- tx_data  output  8  byte to the UART TX
- tx_valid  output  1  tx_data is valid
- tx_ready  input  1  UART TX accepts the byte
- busy  output  1  high from the SNAP state through the end of the GAP state
- frame_done  output  1  one-cycle pulse when the last byte (LF) is accepted
- pending  output  4  coalesced change flags not yet reported

Behaviour:
- Reset (async assert, sync release) forces:
  - state IDLE, pending = 0, tx_valid = 0, tx_data = 0, busy = 0, frame_done = 0;
  - byte index = 0, gap counter = 0, snapshot registers = 0.
- Reset mid-frame aborts immediately. No partial-frame resume.
- pending[i] is set on change[i].
- force_req sets an internal force flag.
- Both set paths work in every state, including during SEND.
- State IDLE: if (pending != 0 or force flag) go to SNAP on the next cycle.
- State SNAP, 1 cycle:
  - Latch ascii0..3 into the snapshot.
  - Clear the pending bits and force flag that were set before this cycle.
  - A change[i] arriving in the SNAP cycle itself leaves pending[i] = 1, so it is reported in the next frame.
  - Go to SEND with index 0.
- State SEND:
  - Frame byte order, 18 bytes total:
    - TAG0, ascii0[23:16], ascii0[15:8], ascii0[7:0]
    - TAG1 + 3 digits of ascii1, TAG2 + 3 digits of ascii2, TAG3 + 3 digits of ascii3
    - 8'h0D, 8'h0A
  - tx_valid = 1 throughout. tx_data is a combinational-free registered function of index and snapshot, so it is stable while tx_valid is high and tx_ready is low.
  - A byte is transferred when tx_valid && tx_ready on a rising clk edge; the index then increments.
  - Back-to-back acceptance with tx_ready held high gives one byte per cycle: frame spans 18 cycles.
  - On acceptance of index 17: tx_valid deasserts the next cycle, frame_done pulses that same cycle, and the state goes to GAP.
  - The frame never reflects counter updates made after SNAP.
- State GAP:
  - Counts GAP_CYCLES clocks with tx_valid = 0, then goes to IDLE.
  - GAP_CYCLES = 0 means GAP lasts 0 cycles, so IDLE is entered directly.
  - Pending events collected meanwhile trigger the next frame from IDLE.
- Latency: change pulse at cycle N, with the block idle and no gap active:
  - SNAP at N+1 (pending visible at N+1);
  - first tx_valid at N+2.
- Multiple changes to the same denomination before SNAP coalesce into one report.
- tx_ready high while tx_valid is low is ignored.
- The index counter is 5 bits and never wraps past 17.
- The gap counter is sized by clog2(GAP_CYCLES+1).

Decomposition:
- Shared package piggy_pkg:
  - state enum (IDLE, SNAP, SEND, GAP);
  - FRAME_LEN = 18;
  - CR/LF constants;
  - default tag constants.
- One natural sub-module: frame_byte_mux. It is a pure function of index, snapshot and tags, selecting the 8-bit byte, and is instantiated inside the scheduler ahead of the tx_data register.

Test Plan:
1. Set ascii0 = "012" (24'h303132), ascii1..3 = "000", tx_ready = 1, pulse change = 4'b0001. Required stream: 54 30 31 32 46 30 30 30 57 30 30 30 4F 30 30 30 0D 0A, one byte per cycle. frame_done pulses once, pending returns to 0.
2. Hold tx_ready low for 5 cycles on byte index 3. Required: tx_valid stays 1, tx_data stays 8'h32 and the index does not advance. Resume tx_ready: the frame completes intact.
3. During SEND, change ascii0 to "013" and pulse change[2]. Required: the current frame still shows "012". After GAP_CYCLES idle cycles, a second frame shows "013", and pending[2] clears at its SNAP.
4. Pulse change[1] three times before SNAP, plus force_req. Required: exactly one frame results; no second frame unless a new event arrives.
5. Assert rst_n low at byte index 9. Required: tx_valid = 0 and pending = 0 asynchronously, before the next clk edge. After release, no bytes are sent until a new change pulse.
6. Pulse change[3] in the exact SNAP cycle of a frame. Required: pending[3] = 1 after SNAP and a second frame follows the gap.
